// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory arbiter: FSM states, arbitration modes, write sizes.
// Write-size values match the pipeline's cache interface.
package mem_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam int MODE_RR    = 0;
    localparam int MODE_FIXED = 1;

    localparam logic [1:0] WS_BYTE = 2'd0;
    localparam logic [1:0] WS_HALF = 2'd1;
    localparam logic [1:0] WS_WORD = 2'd2;

endpackage

// File: rtl/rr_pick.sv
// Rotated priority encoder: first set req bit at or after start, wrapping; start forced to 0 in fixed mode.
// Purely combinational, no state; valid low when no request is present.
module rr_pick #(
    parameter int NPORTS = 2,
    parameter int GW     = 1
) (
    input  logic [NPORTS-1:0] req,
    input  logic [GW-1:0]     start,
    input  logic              mode,
    output logic [GW-1:0]     idx,
    output logic              valid
);

    always_comb begin
        int base;
        int k;
        base  = mode ? 0 : int'(start);
        idx   = '0;
        valid = 1'b0;
        k     = 0;
        for (int i = 0; i < NPORTS; i++) begin
            k = base + i;
            if (k >= NPORTS) k = k - NPORTS;
            if (!valid && req[k]) begin
                valid = 1'b1;
                idx   = GW'(k);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Merges NPORTS cache-style requesters onto one memory port with a single transaction in flight.
// mem_req rises one cycle after p_req; p_rdy is combinational with mem_rdy; losing ports wait holding p_req.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NPORTS = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MODE   = 0,
    localparam int GW    = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NPORTS*ADDR_W-1:0] p_addr,
    input  logic [NPORTS*DATA_W-1:0] p_wdata,
    input  logic [NPORTS*2-1:0]      p_ws,
    input  logic [NPORTS-1:0]        p_req,
    input  logic [NPORTS-1:0]        p_wr,
    output logic [NPORTS*DATA_W-1:0] p_rdata,
    output logic [NPORTS-1:0]        p_rdy,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic [1:0]               mem_ws,
    output logic                     mem_req,
    output logic                     mem_wr,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     mem_rdy,
    output logic                     busy,
    output logic [GW-1:0]            grant
);

    state_t        state, state_nxt;
    logic [GW-1:0] rr_ptr;
    logic [GW-1:0] win;
    logic          win_vld;
    logic          done;

    rr_pick #(
        .NPORTS (NPORTS),
        .GW     (GW)
    ) u_pick (
        .req   (p_req),
        .start (rr_ptr),
        .mode  (MODE == MODE_FIXED),
        .idx   (win),
        .valid (win_vld)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        mem_req   = 1'b0;
        busy      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (win_vld) state_nxt = ST_BUSY;
            end
            ST_BUSY: begin
                mem_req = 1'b1;
                busy    = 1'b1;
                if (mem_rdy) begin
                    done      = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Request fields are captured at grant so the requester may change them while BUSY.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_ws    <= '0;
            mem_wr    <= 1'b0;
            grant     <= '0;
            rr_ptr    <= '0;
        end else begin
            if (state == ST_IDLE && win_vld) begin
                mem_addr  <= p_addr[win*ADDR_W +: ADDR_W];
                mem_wdata <= p_wdata[win*DATA_W +: DATA_W];
                mem_ws    <= p_ws[win*2 +: 2];
                mem_wr    <= p_wr[win];
                grant     <= win;
            end
            if (done) rr_ptr <= (grant == GW'(NPORTS-1)) ? '0 : grant + GW'(1);
        end
    end

    always_comb begin
        p_rdy   = '0;
        p_rdata = '0;
        if (done) begin
            p_rdy[grant]                     = 1'b1;
            p_rdata[grant*DATA_W +: DATA_W]  = mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (2-port RR, 2-port fixed, 4-port RR) share one stimulus bus selected by sel.
// Completions are checked against a scoreboard of expected {port, data} pushed when mem_rdy is driven.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clock, reset;
    int   sel;

    logic [3:0]   d_req, d_wr;
    logic [127:0] d_addr, d_wdata;
    logic [7:0]   d_ws;
    logic         d_mem_rdy;
    logic [31:0]  d_mem_rdata;

    logic [63:0] a_p_rdata, b_p_rdata;
    logic [127:0] c_p_rdata;
    logic [1:0]  a_p_rdy, b_p_rdy;
    logic [3:0]  c_p_rdy;
    logic [31:0] a_mem_addr, b_mem_addr, c_mem_addr, a_mem_wdata, b_mem_wdata, c_mem_wdata;
    logic [1:0]  a_mem_ws, b_mem_ws, c_mem_ws;
    logic        a_mem_req, b_mem_req, c_mem_req, a_mem_wr, b_mem_wr, c_mem_wr;
    logic        a_busy, b_busy, c_busy;
    logic        a_grant, b_grant;
    logic [1:0]  c_grant;

    logic         o_mem_req, o_mem_wr, o_busy;
    logic [1:0]   o_grant, o_mem_ws;
    logic [31:0]  o_mem_addr, o_mem_wdata;
    logic [3:0]   o_p_rdy;
    logic [127:0] o_p_rdata;

    mem_arbiter #(.NPORTS(2), .MODE(0)) u_a (
        .clock(clock), .reset(reset),
        .p_addr(d_addr[63:0]), .p_wdata(d_wdata[63:0]), .p_ws(d_ws[3:0]),
        .p_req(d_req[1:0] & {2{sel == 0}}), .p_wr(d_wr[1:0]),
        .p_rdata(a_p_rdata), .p_rdy(a_p_rdy),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_ws(a_mem_ws),
        .mem_req(a_mem_req), .mem_wr(a_mem_wr),
        .mem_rdata(d_mem_rdata), .mem_rdy(d_mem_rdy & (sel == 0)),
        .busy(a_busy), .grant(a_grant)
    );

    mem_arbiter #(.NPORTS(2), .MODE(1)) u_b (
        .clock(clock), .reset(reset),
        .p_addr(d_addr[63:0]), .p_wdata(d_wdata[63:0]), .p_ws(d_ws[3:0]),
        .p_req(d_req[1:0] & {2{sel == 1}}), .p_wr(d_wr[1:0]),
        .p_rdata(b_p_rdata), .p_rdy(b_p_rdy),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_ws(b_mem_ws),
        .mem_req(b_mem_req), .mem_wr(b_mem_wr),
        .mem_rdata(d_mem_rdata), .mem_rdy(d_mem_rdy & (sel == 1)),
        .busy(b_busy), .grant(b_grant)
    );

    mem_arbiter #(.NPORTS(4), .MODE(0)) u_c (
        .clock(clock), .reset(reset),
        .p_addr(d_addr), .p_wdata(d_wdata), .p_ws(d_ws),
        .p_req(d_req & {4{sel == 2}}), .p_wr(d_wr),
        .p_rdata(c_p_rdata), .p_rdy(c_p_rdy),
        .mem_addr(c_mem_addr), .mem_wdata(c_mem_wdata), .mem_ws(c_mem_ws),
        .mem_req(c_mem_req), .mem_wr(c_mem_wr),
        .mem_rdata(d_mem_rdata), .mem_rdy(d_mem_rdy & (sel == 2)),
        .busy(c_busy), .grant(c_grant)
    );

    always_comb begin
        o_mem_req = 1'b0; o_mem_wr = 1'b0; o_busy = 1'b0; o_grant = '0; o_mem_ws = '0;
        o_mem_addr = '0; o_mem_wdata = '0; o_p_rdy = '0; o_p_rdata = '0;
        case (sel)
            0: begin
                o_mem_req = a_mem_req; o_mem_wr = a_mem_wr; o_busy = a_busy; o_grant = {1'b0, a_grant};
                o_mem_ws = a_mem_ws; o_mem_addr = a_mem_addr; o_mem_wdata = a_mem_wdata;
                o_p_rdy = {2'b0, a_p_rdy}; o_p_rdata = {64'b0, a_p_rdata};
            end
            1: begin
                o_mem_req = b_mem_req; o_mem_wr = b_mem_wr; o_busy = b_busy; o_grant = {1'b0, b_grant};
                o_mem_ws = b_mem_ws; o_mem_addr = b_mem_addr; o_mem_wdata = b_mem_wdata;
                o_p_rdy = {2'b0, b_p_rdy}; o_p_rdata = {64'b0, b_p_rdata};
            end
            default: begin
                o_mem_req = c_mem_req; o_mem_wr = c_mem_wr; o_busy = c_busy; o_grant = c_grant;
                o_mem_ws = c_mem_ws; o_mem_addr = c_mem_addr; o_mem_wdata = c_mem_wdata;
                o_p_rdy = c_p_rdy; o_p_rdata = c_p_rdata;
            end
        endcase
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int fails  = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    typedef struct {
        int          port;
        logic [31:0] data;
    } sb_t;
    sb_t sb[$];

    always @(negedge clock) begin
        if (!reset && o_p_rdy != 4'b0) begin
            if (sb.size() == 0) begin
                check("unexpected_p_rdy", {60'b0, o_p_rdy}, 64'd0);
            end else begin
                sb_t e;
                logic [127:0] m;
                e = sb.pop_front();
                m = '1;
                m[e.port*32 +: 32] = 32'h0;
                check("sb_p_rdy", {60'b0, o_p_rdy}, 64'(4'b0001 << e.port));
                check("sb_p_rdata", {32'b0, o_p_rdata[e.port*32 +: 32]}, {32'b0, e.data});
                check("sb_p_rdata_other_zero", {63'b0, |(o_p_rdata & m)}, 64'd0);
            end
        end
    end

    typedef struct {
        logic [3:0]  req;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wr;
        logic [1:0]  ws;
        logic [31:0] rdata;
        int          delay;
        int          exp_port;
        bit          scramble;
    } vec_t;

    task automatic reset_dut(input int s);
        sel = s;
        d_req = '0; d_wr = '0; d_addr = '0; d_wdata = '0; d_ws = '0;
        d_mem_rdy = 1'b0; d_mem_rdata = '0;
        reset = 1'b1;
        @(negedge clock);
        check("rst_mem_req", {63'b0, o_mem_req}, 64'd0);
        check("rst_busy", {63'b0, o_busy}, 64'd0);
        check("rst_mem_wr", {63'b0, o_mem_wr}, 64'd0);
        check("rst_grant", {62'b0, o_grant}, 64'd0);
        check("rst_mem_addr", {32'b0, o_mem_addr}, 64'd0);
        check("rst_mem_wdata", {32'b0, o_mem_wdata}, 64'd0);
        check("rst_mem_ws", {62'b0, o_mem_ws}, 64'd0);
        check("rst_p_rdy", {60'b0, o_p_rdy}, 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    // Port i gets addr base+16*i, wdata ~(base+i), alternating wr, size i%3.
    task automatic drive_ports(input logic [31:0] base);
        for (int i = 0; i < 4; i++) begin
            d_addr[i*32 +: 32]  = base + 32'(16*i);
            d_wdata[i*32 +: 32] = ~(base + 32'(i));
            d_wr[i]             = i[0];
            d_ws[i*2 +: 2]      = 2'(i % 3);
        end
    endtask

    // drop: 0 keep requests, 1 drop the granted port, 2 drop all ports.
    task automatic txn(input int exp_port, input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                       input logic exp_wr, input logic [1:0] exp_ws, input int delay,
                       input bit scramble, input int drop, input bit check_lat);
        int n;
        logic [31:0] rd;
        n = 0;
        @(negedge clock);
        while (!o_mem_req && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("mem_req_timeout", {63'b0, o_mem_req}, 64'd1);
        if (!o_mem_req) return;
        if (check_lat) check("req_to_mem_req_latency", 64'(n), 64'd0);
        check("grant", {62'b0, o_grant}, 64'(exp_port));
        check("busy", {63'b0, o_busy}, 64'd1);
        check("mem_addr", {32'b0, o_mem_addr}, {32'b0, exp_addr});
        check("mem_wdata", {32'b0, o_mem_wdata}, {32'b0, exp_wdata});
        check("mem_wr", {63'b0, o_mem_wr}, {63'b0, exp_wr});
        check("mem_ws", {62'b0, o_mem_ws}, {62'b0, exp_ws});
        for (int c = 0; c < delay; c++) begin
            @(posedge clock); #1;
            if (scramble && c == 0) begin
                d_addr = ~d_addr; d_wdata = ~d_wdata; d_ws = ~d_ws; d_wr = ~d_wr;
            end
            @(negedge clock);
            check("stable_mem_req", {63'b0, o_mem_req}, 64'd1);
            check("stable_mem_addr", {32'b0, o_mem_addr}, {32'b0, exp_addr});
            check("stable_mem_wdata", {32'b0, o_mem_wdata}, {32'b0, exp_wdata});
            check("stable_mem_wr_ws", {61'b0, o_mem_wr, o_mem_ws}, {61'b0, exp_wr, exp_ws});
            check("no_early_p_rdy", {60'b0, o_p_rdy}, 64'd0);
        end
        @(posedge clock); #1;
        rd = $urandom;
        d_mem_rdy = 1'b1;
        d_mem_rdata = rd;
        sb.push_back('{exp_port, rd});
        @(negedge clock);
        check("p_rdy_with_mem_rdy", {60'b0, o_p_rdy}, 64'(4'b0001 << exp_port));
        @(posedge clock); #1;
        d_mem_rdy = 1'b0;
        d_mem_rdata = $urandom;
        if (drop == 1) d_req[exp_port] = 1'b0;
        if (drop == 2) d_req = '0;
        @(negedge clock);
        check("idle_gap_busy", {63'b0, o_busy}, 64'd0);
        check("idle_gap_mem_req", {63'b0, o_mem_req}, 64'd0);
    endtask

    function automatic int rr_model(input logic [3:0] req, input int ptr, input int n);
        for (int i = 0; i < n; i++) begin
            if (req[(ptr + i) % n]) return (ptr + i) % n;
        end
        return -1;
    endfunction

    vec_t vecs[7];

    initial begin
        int ptr, g;
        reset = 1'b1;
        sel = 0;
        d_req = '0; d_wr = '0; d_addr = '0; d_wdata = '0; d_ws = '0;
        d_mem_rdy = 1'b0; d_mem_rdata = '0;

        vecs[0] = '{4'b0001, 32'h0000_0100, 32'h0000_0000, 1'b0, WS_WORD, 32'hDEADBEEF, 3, 0, 1'b0};
        vecs[1] = '{4'b0011, 32'h0000_0200, 32'hA5A5_0001, 1'b0, WS_WORD, 32'h1111_2222, 1, 1, 1'b0};
        vecs[2] = '{4'b0010, 32'h0000_0300, 32'h0000_1234, 1'b1, WS_HALF, 32'h0,         3, 1, 1'b1};
        vecs[3] = '{4'b0011, 32'h0000_0400, 32'h0BAD_F00D, 1'b1, WS_BYTE, 32'h3333_4444, 2, 0, 1'b0};
        vecs[4] = '{4'b0001, 32'h0000_0500, 32'h5555_AAAA, 1'b0, WS_HALF, 32'h5555_6666, 0, 0, 1'b0};
        vecs[5] = '{4'b0011, 32'h0000_0600, 32'hCAFE_BABE, 1'b0, WS_WORD, 32'h7777_8888, 1, 1, 1'b1};
        vecs[6] = '{4'b0010, 32'h0000_0700, 32'h0000_00EE, 1'b1, WS_BYTE, 32'h9999_0000, 0, 1, 1'b0};

        // Table vectors on the 2-port round-robin instance, pointer carried across vectors.
        reset_dut(0);
        foreach (vecs[v]) begin
            @(posedge clock); #1;
            for (int i = 0; i < 4; i++) begin
                d_addr[i*32 +: 32]  = (i == vecs[v].exp_port) ? vecs[v].addr  : ~vecs[v].addr;
                d_wdata[i*32 +: 32] = (i == vecs[v].exp_port) ? vecs[v].wdata : ~vecs[v].wdata;
                d_ws[i*2 +: 2]      = (i == vecs[v].exp_port) ? vecs[v].ws    : ~vecs[v].ws;
                d_wr[i]             = (i == vecs[v].exp_port) ? vecs[v].wr    : ~vecs[v].wr;
            end
            d_req = vecs[v].req;
            @(negedge clock);
            check("mem_req_not_yet", {63'b0, o_mem_req}, 64'd0);
            txn(vecs[v].exp_port, vecs[v].addr, vecs[v].wdata, vecs[v].wr, vecs[v].ws,
                vecs[v].delay, vecs[v].scramble, 2, 1'b1);
        end

        // Both ports held, round-robin from reset: alternating grants.
        reset_dut(0);
        @(posedge clock); #1;
        drive_ports(32'h0000_3000);
        d_req = 4'b0011;
        ptr = 0;
        for (int t = 0; t < 4; t++) begin
            g = rr_model(d_req, ptr, 2);
            txn(g, 32'h3000 + 32'(16*g), ~(32'h3000 + 32'(g)), g[0], 2'(g % 3), 1, 1'b0,
                (t == 3) ? 2 : 0, 1'b0);
            ptr = (g + 1) % 2;
        end

        // Fixed priority: port 0 keeps winning until it stops requesting.
        reset_dut(1);
        @(posedge clock); #1;
        drive_ports(32'h0000_2000);
        d_req = 4'b0011;
        txn(0, 32'h2000, ~32'h2000, 1'b0, 2'd0, 1, 1'b0, 0, 1'b0);
        txn(0, 32'h2000, ~32'h2000, 1'b0, 2'd0, 0, 1'b0, 0, 1'b0);
        txn(0, 32'h2000, ~32'h2000, 1'b0, 2'd0, 2, 1'b0, 1, 1'b0);
        txn(1, 32'h2010, ~32'h2001, 1'b1, 2'd1, 1, 1'b0, 2, 1'b0);

        // Reset in the middle of a transaction; pointer must restart at 0.
        reset_dut(0);
        @(posedge clock); #1;
        drive_ports(32'h0000_0400);
        d_req = 4'b0001;
        txn(0, 32'h0400, ~32'h0400, 1'b0, 2'd0, 1, 1'b0, 2, 1'b0);
        @(posedge clock); #1;
        drive_ports(32'h0000_0500);
        d_req = 4'b0010;
        @(negedge clock);
        @(negedge clock);
        check("abort_busy_before_reset", {63'b0, o_busy}, 64'd1);
        check("abort_grant_before_reset", {62'b0, o_grant}, 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("abort_mem_req_drop", {63'b0, o_mem_req}, 64'd0);
        check("abort_busy_drop", {63'b0, o_busy}, 64'd0);
        check("abort_p_rdy", {60'b0, o_p_rdy}, 64'd0);
        check("abort_grant_clr", {62'b0, o_grant}, 64'd0);
        check("abort_mem_addr_clr", {32'b0, o_mem_addr}, 64'd0);
        d_mem_rdy = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        d_req = '0;
        @(negedge clock);
        check("late_mem_rdy_no_p_rdy", {60'b0, o_p_rdy}, 64'd0);
        check("late_mem_rdy_idle", {63'b0, o_busy}, 64'd0);
        @(posedge clock); #1;
        d_mem_rdy = 1'b0;
        drive_ports(32'h0000_0600);
        d_req = 4'b0011;
        txn(0, 32'h0600, ~32'h0600, 1'b0, 2'd0, 1, 1'b0, 2, 1'b0);

        // 4 ports: stray mem_rdy in IDLE, then all requesting with wrap.
        reset_dut(2);
        @(posedge clock); #1;
        d_mem_rdy = 1'b1;
        d_mem_rdata = 32'hFFFF_FFFF;
        @(negedge clock);
        check("stray_mem_rdy_p_rdy", {60'b0, o_p_rdy}, 64'd0);
        check("stray_mem_rdy_busy", {63'b0, o_busy}, 64'd0);
        @(posedge clock); #1;
        d_mem_rdy = 1'b0;
        drive_ports(32'h0000_8000);
        d_req = 4'b1111;
        ptr = 0;
        for (int t = 0; t < 5; t++) begin
            g = rr_model(d_req, ptr, 4);
            txn(g, 32'h8000 + 32'(16*g), ~(32'h8000 + 32'(g)), g[0], 2'(g % 3), t % 3, 1'b0,
                (t == 4) ? 2 : 0, 1'b0);
            ptr = (g + 1) % 4;
        end
        check("wrap_last_grant", 64'(g), 64'd0);

        repeat (2) @(negedge clock);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, %0d checks made", checks);
        $fatal(1, "timeout");
    end

endmodule
